// File: rtl/copy_cmd_dispatch.sv
// copy_cmd_dispatch: descriptor FIFO and start/done sequencer in front of the copy engine; watchdog via COPY_DISPATCH_WATCHDOG_EN
module copy_cmd_dispatch #(
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [63:0]              cmd_src,
   input  logic [63:0]              cmd_dst,
   output logic [63:0]              eng_src_addr,
   output logic [63:0]              eng_dst_addr,
   output logic                     eng_start,
   input  logic                     eng_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]         cmpl_count,
   output logic                     err
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t        state_q, state_d;
   logic [127:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          push, pop, load, done_ok, timeout;
   assign cmd_ready = fifo_level != (AW+1)'(DEPTH);
   assign push      = cmd_valid && cmd_ready;
   assign done_ok   = state_q == S_WAIT && eng_done;
   assign pop       = done_ok || timeout;
   assign busy      = fifo_level != '0 || state_q != S_IDLE;
`ifdef COPY_DISPATCH_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT+1);
   logic [WW-1:0] wd_cnt;
   logic          err_q;
   // a done in the final watchdog cycle wins over the timeout
   assign timeout = state_q == S_WAIT && !eng_done && wd_cnt == WW'(TIMEOUT-1);
   assign err     = err_q;
   // watchdog cycle counter and sticky error
   always_ff @(posedge clk)
      if (!rst_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         wd_cnt <= load ? '0 : state_q == S_WAIT ? wd_cnt + 1'b1 : wd_cnt;
         if (timeout) err_q <= 1'b1;
      end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
   // descriptor storage; contents need no reset since pointers define validity
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {cmd_src, cmd_dst};
   // FIFO pointers and level; the head is popped only when its transfer ends
   always_ff @(posedge clk)
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      end
   // FSM state register
   always_ff @(posedge clk)
      if (!rst_n) state_q <= S_IDLE;
      else state_q <= state_d;
   // FSM next state
   always_comb
      state_d = state_q == S_IDLE ? (fifo_level != '0 ? S_WAIT : S_IDLE) : (pop ? S_IDLE : S_WAIT);
   // FSM output decode: issue the head when idle and something is queued
   always_comb
      load = state_q == S_IDLE && fifo_level != '0;
   // registered engine interface; addresses move only when a descriptor is issued
   always_ff @(posedge clk)
      if (!rst_n) begin
         eng_start    <= 1'b0;
         eng_src_addr <= '0;
         eng_dst_addr <= '0;
      end else begin
         eng_start <= load;
         if (load) {eng_src_addr, eng_dst_addr} <= mem[rd_ptr];
      end
   // completion counter, wraps naturally
   always_ff @(posedge clk)
      if (!rst_n) cmpl_count <= '0;
      else if (done_ok) cmpl_count <= cmpl_count + 1'b1;
endmodule

// File: tb/tb_copy_cmd_dispatch.sv
// tb_copy_cmd_dispatch: scoreboard bench for the copy command dispatcher
module tb_copy_cmd_dispatch;
   logic        clk = 0, rst_n = 0, cmd_valid = 0, man_done = 0, auto_done = 0;
   logic [63:0] cmd_src = 0, cmd_dst = 0;
   wire  logic  eng_done = man_done | auto_done;
   logic        cmd_ready, eng_start, busy, err;
   logic [63:0] eng_src_addr, eng_dst_addr;
   logic [3:0]  fifo_level;
   logic [31:0] cmpl_count;
   int          vectors = 0, miscompares = 0, n_starts = 0, base = 0, lat = 4, cnt = 0;
   bit          auto_en = 0, wd_mode = 0, active = 0;
   logic [127:0] sb[$];
   logic [127:0] exp_d;

   copy_cmd_dispatch #(.DEPTH(8), .CNT_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .eng_src_addr(eng_src_addr),
      .eng_dst_addr(eng_dst_addr), .eng_start(eng_start), .eng_done(eng_done),
      .busy(busy), .fifo_level(fifo_level), .cmpl_count(cmpl_count), .err(err));

   always #5 clk = ~clk;

   // engine model and scoreboard check on every start pulse
   always @(negedge clk) begin
      #1;
      auto_done = 0;
      if (!rst_n) active = 0;
      else if (eng_start) begin
         n_starts++;
         vectors++;
         if (active && !wd_mode) begin
            miscompares++;
            $display("FAIL start_while_busy: eng_start=1 while engine mid-transfer, required 0");
         end
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL start_unexpected: start with src=%h dst=%h, no descriptor queued", eng_src_addr, eng_dst_addr);
         end else begin
            exp_d = sb.pop_front();
            if ({eng_src_addr, eng_dst_addr} !== exp_d) begin
               miscompares++;
               $display("FAIL start_addr: got src=%h dst=%h, required src=%h dst=%h", eng_src_addr, eng_dst_addr, exp_d[127:64], exp_d[63:0]);
            end
         end
         active = 1;
         cnt = lat;
      end else if (active && auto_en) begin
         cnt--;
         if (cnt == 0) begin
            auto_done = 1;
            active = 0;
         end
      end else if (active && man_done) active = 0;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic apply_reset;
      cmd_valid = 0;
      man_done = 0;
      auto_en = 0;
      wd_mode = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      sb.delete();
      base = n_starts;
   endtask

   task automatic push_cmd(input logic [63:0] s, input logic [63:0] d);
      cmd_valid = 1;
      cmd_src = s;
      cmd_dst = d;
      for (int i = 0; i < 300; i++) begin
         if (cmd_ready) begin
            sb.push_back({s, d});
            @(negedge clk);
            cmd_valid = 0;
            return;
         end
         @(negedge clk);
      end
      cmd_valid = 0;
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: cmd_ready=%b, required 1 within 300 cycles", cmd_ready);
   endtask

   task automatic wait_starts(input int n);
      for (int i = 0; i < 300; i++) begin
         if (n_starts >= n) return;
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL start_timeout: starts=%0d, required %0d", n_starts, n);
   endtask

   task automatic do_done;
      man_done = 1;
      @(negedge clk);
      man_done = 0;
   endtask

   task automatic test_reset;
      apply_reset();
      vectors++;
      if ({cmd_ready, busy, eng_start, err} !== 4'b1000) begin
         miscompares++;
         $display("FAIL reset_flags: ready/busy/start/err=%b, required 1000", {cmd_ready, busy, eng_start, err});
      end
      vectors++;
      if (fifo_level !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_level: got %0d, required 0", fifo_level);
      end
      vectors++;
      if (eng_src_addr !== 64'd0 || eng_dst_addr !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_addr: got %h/%h, required 0/0", eng_src_addr, eng_dst_addr);
      end
      vectors++;
      if (cmpl_count !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d, required 0", cmpl_count);
      end
   endtask

   task automatic test_single;
      apply_reset();
      cmd_valid = 1;
      cmd_src = 64'h1000;
      cmd_dst = 64'h2000;
      sb.push_back({64'h1000, 64'h2000});
      @(negedge clk);
      cmd_valid = 0;
      vectors++;
      if (fifo_level !== 4'd1 || eng_start !== 1'b0) begin
         miscompares++;
         $display("FAIL single_after_push: level=%0d start=%b, required 1/0", fifo_level, eng_start);
      end
      @(negedge clk);
      vectors++;
      if (eng_start !== 1'b1 || eng_src_addr !== 64'h1000 || eng_dst_addr !== 64'h2000) begin
         miscompares++;
         $display("FAIL single_start: start=%b src=%h dst=%h, required 1/1000/2000", eng_start, eng_src_addr, eng_dst_addr);
      end
      @(negedge clk);
      vectors++;
      if (eng_start !== 1'b0 || eng_src_addr !== 64'h1000 || eng_dst_addr !== 64'h2000 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_hold: start=%b src=%h dst=%h busy=%b, required 0/1000/2000/1", eng_start, eng_src_addr, eng_dst_addr, busy);
      end
      repeat (2) @(negedge clk);
      do_done();
      vectors++;
      if (cmpl_count !== 32'd1 || fifo_level !== 4'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: count=%0d level=%0d busy=%b, required 1/0/0", cmpl_count, fifo_level, busy);
      end
      vectors++;
      if (n_starts - base !== 1) begin
         miscompares++;
         $display("FAIL single_starts: got %0d, required 1", n_starts - base);
      end
   endtask

   task automatic test_fill;
      apply_reset();
      for (int i = 0; i < 8; i++) push_cmd(64'h10000 + 64'(i) * 64, 64'h80000 + 64'(i) * 64);
      vectors++;
      if (fifo_level !== 4'd8 || cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: level=%0d ready=%b, required 8/0", fifo_level, cmd_ready);
      end
      cmd_valid = 1;
      cmd_src = 64'hDEAD;
      cmd_dst = 64'hBEEF;
      repeat (3) @(negedge clk);
      cmd_valid = 0;
      vectors++;
      if (fifo_level !== 4'd8) begin
         miscompares++;
         $display("FAIL fill_refuse: level=%0d, required 8", fifo_level);
      end
      for (int i = 0; i < 8; i++) begin
         wait_starts(base + i + 1);
         @(negedge clk);
         do_done();
      end
      @(negedge clk);
      vectors++;
      if (cmpl_count !== 32'd8 || fifo_level !== 4'd0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL fill_drain: count=%0d level=%0d pending=%0d, required 8/0/0", cmpl_count, fifo_level, sb.size());
      end
   endtask

   task automatic test_wrap;
      apply_reset();
      auto_en = 1;
      lat = 4;
      for (int i = 0; i < 20; i++) push_cmd(64'hA000_0000 + 64'(i) * 4096, 64'hB000_0008 + 64'(i) * 4096);
      for (int i = 0; i < 500 && cmpl_count != 32'd20; i++) @(negedge clk);
      vectors++;
      if (cmpl_count !== 32'd20 || n_starts - base !== 20 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL wrap_stream: count=%0d starts=%0d pending=%0d, required 20/20/0", cmpl_count, n_starts - base, sb.size());
      end
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_idle: err=%b busy=%b, required 0/0", err, busy);
      end
      auto_en = 0;
   endtask

   task automatic test_simul;
      apply_reset();
      for (int i = 0; i < 3; i++) push_cmd(64'h300 + 64'(i), 64'h700 + 64'(i));
      wait_starts(base + 1);
      vectors++;
      if (fifo_level !== 4'd3) begin
         miscompares++;
         $display("FAIL simul_pre: level=%0d, required 3", fifo_level);
      end
      cmd_valid = 1;
      cmd_src = 64'h3FF;
      cmd_dst = 64'h7FF;
      sb.push_back({64'h3FF, 64'h7FF});
      man_done = 1;
      @(negedge clk);
      cmd_valid = 0;
      man_done = 0;
      vectors++;
      if (fifo_level !== 4'd3 || cmpl_count !== 32'd1) begin
         miscompares++;
         $display("FAIL simul_level: level=%0d count=%0d, required 3/1", fifo_level, cmpl_count);
      end
      for (int i = 0; i < 3; i++) begin
         wait_starts(base + 2 + i);
         @(negedge clk);
         do_done();
      end
      @(negedge clk);
      vectors++;
      if (cmpl_count !== 32'd4 || fifo_level !== 4'd0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL simul_drain: count=%0d level=%0d pending=%0d, required 4/0/0", cmpl_count, fifo_level, sb.size());
      end
   endtask

   task automatic test_reset_mid;
      apply_reset();
      for (int i = 0; i < 4; i++) push_cmd(64'h5000 + 64'(i) * 16, 64'h6000 + 64'(i) * 16);
      wait_starts(base + 1);
      vectors++;
      if (fifo_level !== 4'd4 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_pre: level=%0d busy=%b, required 4/1", fifo_level, busy);
      end
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      sb.delete();
      vectors++;
      if ({cmd_ready, busy, eng_start, err} !== 4'b1000 || fifo_level !== 4'd0 || eng_src_addr !== 64'd0 || eng_dst_addr !== 64'd0) begin
         miscompares++;
         $display("FAIL rstmid_state: ready/busy/start/err=%b level=%0d src=%h dst=%h, required 1000/0/0/0", {cmd_ready, busy, eng_start, err}, fifo_level, eng_src_addr, eng_dst_addr);
      end
      do_done();
      repeat (3) @(negedge clk);
      vectors++;
      if (cmpl_count !== 32'd0 || busy !== 1'b0 || n_starts - base !== 1) begin
         miscompares++;
         $display("FAIL rstmid_stray_done: count=%0d busy=%b starts=%0d, required 0/0/1", cmpl_count, busy, n_starts - base);
      end
   endtask

`ifdef COPY_DISPATCH_WATCHDOG_EN
   task automatic test_watchdog;
      apply_reset();
      push_cmd(64'h9000, 64'h9100);
      wd_mode = 1;
      push_cmd(64'h9200, 64'h9300);
      for (int i = 0; i < 20 && eng_start !== 1'b1; i++) @(negedge clk);
      repeat (15) @(negedge clk);
      vectors++;
      if (err !== 1'b0 || fifo_level !== 4'd2) begin
         miscompares++;
         $display("FAIL wd_early: err=%b level=%0d, required 0/2", err, fifo_level);
      end
      @(negedge clk);
      vectors++;
      if (err !== 1'b1 || cmpl_count !== 32'd0 || fifo_level !== 4'd1) begin
         miscompares++;
         $display("FAIL wd_fire: err=%b count=%0d level=%0d, required 1/0/1", err, cmpl_count, fifo_level);
      end
      @(negedge clk);
      vectors++;
      if (eng_start !== 1'b1 || eng_src_addr !== 64'h9200) begin
         miscompares++;
         $display("FAIL wd_next: start=%b src=%h, required 1/9200", eng_start, eng_src_addr);
      end
      @(negedge clk);
      do_done();
      vectors++;
      if (cmpl_count !== 32'd1 || err !== 1'b1 || fifo_level !== 4'd0) begin
         miscompares++;
         $display("FAIL wd_after: count=%0d err=%b level=%0d, required 1/1/0", cmpl_count, err, fifo_level);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_wrap();
      test_simul();
      test_reset_mid();
`ifdef COPY_DISPATCH_WATCHDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/copy_cmd_dispatch.md
Name: copy_cmd_dispatch

Overview:
- Command queue and sequencer directly upstream of the copy engine.
- Accepts (src, dst) copy descriptors from the host-side control path through a valid/ready interface and buffers them in a FIFO.
- Issues descriptors to the copy engine one at a time: a one-cycle start pulse, then addresses held stable until the engine's done pulse.
- Counts completed transfers and reports busy status.

Parameters:
- DEPTH, 8: FIFO depth in descriptors; power of two, at least 2.
- CNT_W, 32: width of the completion counter.
- TIMEOUT, 4096: watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cmd_valid  in  1  descriptor present on cmd_src/cmd_dst.
- cmd_ready  out  1  FIFO can accept a descriptor; equals !full.
- cmd_src  in  64  source byte address.
- cmd_dst  in  64  destination byte address.
- eng_src_addr  out  64  source address to the copy engine; registered.
- eng_dst_addr  out  64  destination address to the copy engine; registered.
- eng_start  out  1  one-cycle start pulse to the engine; registered.
- eng_done  in  1  one-cycle completion pulse from the engine.
- busy  out  1  high when the FIFO is non-empty or the state is not IDLE.
- fifo_level  out  $clog2(DEPTH)+1  number of queued descriptors, including the one in flight.
- cmpl_count  out  CNT_W  number of completed transfers.
- err  out  1  sticky watchdog error; tied 0 when the optional feature is disabled.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied; fifo_level=0; cmd_ready=1.
  - eng_start=0; eng_src_addr=eng_dst_addr=0; cmpl_count=0; err=0; busy=0; state=IDLE.
  - Reset mid-transfer discards every queued and in-flight descriptor.
  - A late eng_done arriving after reset is ignored because the state is IDLE.
- Push: occurs at a clk edge when cmd_valid && cmd_ready. cmd_ready derives from the registered level, so a full FIFO refuses a push even while a pop happens in the same cycle.
- FIFO:
  - Circular buffer with wrap-around of the read and write pointers at DEPTH.
  - The head entry stays in the FIFO until its transfer completes.
  - Push and pop in the same cycle leave fifo_level unchanged.
- FSM:
  - IDLE: if the FIFO is non-empty, latch the head into eng_src_addr/eng_dst_addr, set eng_start=1, and go to WAIT.
  - WAIT: eng_start=0 (the pulse lasts exactly one cycle). Addresses are held. On eng_done: pop the head, cmpl_count+1 (wraps modulo 2^CNT_W), go to IDLE.
  - eng_done seen in IDLE is ignored, with no count and no pop.
- Latency: a descriptor pushed into an empty, idle block at edge N drives eng_start=1 during the cycle after edge N+1.
  - Back-to-back descriptors have one IDLE cycle between done and the next start.
  - The engine must never see start while it is mid-transfer.
- Address outputs change only on the IDLE->WAIT transition.

Optional Feature:
- Macro: COPY_DISPATCH_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entering WAIT and increments every cycle in WAIT.
  - If it reaches TIMEOUT without eng_done: err set sticky (cleared only by reset), head popped without incrementing cmpl_count, state returns to IDLE.
  - The queue continues with the next descriptor.
  - eng_done in the same cycle as timeout counts as completion, with no error.
- Undefined: no counter logic; err tied 0; WAIT waits indefinitely.

Test Plan:
- Single command: push src=0x1000, dst=0x2000 at edge 0 -> eng_start high exactly one cycle after edge 1, addresses 0x1000/0x2000 held; eng_done 3 cycles later -> cmpl_count=1, fifo_level=0, busy=0 one cycle later.
- Fill: push 8 descriptors with the engine stalled (no done) -> cmd_ready=0 after the 8th; a 9th cmd_valid is not accepted; completing 8 dones in order yields eng_src_addr sequence equal to the push order, cmpl_count=8.
- Wrap-around: 20 descriptors streamed with a 4-cycle engine model -> all 20 issued in order, exactly one start per done, never start while in WAIT.
- Simultaneous push and pop: with FIFO level 3, push in the same cycle as eng_done -> fifo_level stays 3.
- Reset mid-operation: rst_n=0 for 1 cycle during WAIT with 4 queued -> all outputs at reset values; a subsequent stray eng_done leaves cmpl_count=0.
- Watchdog (macro defined, TIMEOUT=16): withhold eng_done -> err=1 after 16 WAIT cycles, cmpl_count unchanged, next descriptor issued.
